arduino_rx_comandos: RTL and testbench

ARDUINO_RX_COMANDOS -- requirements
Module: arduino_rx_comandos

---
 rtl/arduino_rx_comandos.sv | 86 ++++++++
 tb/tb_arduino_rx_comandos.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/arduino_rx_comandos.sv
// arduino_rx_comandos: 8N1 UART receiver that decodes Arduino key commands into pulses and held key levels
module arduino_rx_comandos #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        right_arrow_pressed,
  output logic        left_arrow_pressed,
  output logic        enter_pressed,
  output logic [12:0] botoes,
  output logic [7:0]  dado,
  output logic        byte_valido,
  output logic        erro_quadro
);
  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int TW = DIV > 2 ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_nx;
  logic rx_m, rx_s;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [7:0] sh;
  logic tick, tick_half, sample, accept, frame_err, timer_clr;
  logic in_range;
  logic [12:0] mask, botoes_nx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx, rx_m};
  assign tick = timer == LAST;
  assign tick_half = timer == HALF;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = rx_s ? IDLE : START;
      START:   state_nx = !tick_half ? START : rx_s ? IDLE : DATA;
      DATA:    state_nx = tick && idx == 3'd7 ? STOP : DATA;
      STOP:    state_nx = !tick ? STOP : rx_s ? IDLE : BREAK;
      BREAK:   state_nx = rx_s ? IDLE : BREAK;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    sample = state == DATA && tick;
    accept = state == STOP && tick && rx_s;
    frame_err = state == STOP && tick && !rx_s;
    timer_clr = state == IDLE || state == BREAK || (state == START && tick_half) ||
                ((state == DATA || state == STOP) && tick);
  end
  // Key commands carry the key number in the low nibble; 13..15 are not keys
  assign in_range = sh[3:0] < 4'd13;
  assign mask = 13'd1 << sh[3:0];
  assign botoes_nx = sh == 8'h00 ? '0 :
                     sh[7:4] == 4'h8 && in_range ? botoes | mask :
                     sh[7:4] == 4'hC && in_range ? botoes & ~mask : botoes;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      timer <= '0;
      idx <= '0;
      sh <= '0;
      dado <= '0;
      botoes <= '0;
      byte_valido <= 1'b0;
      erro_quadro <= 1'b0;
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed <= 1'b0;
      enter_pressed <= 1'b0;
    end else begin
      timer <= timer_clr ? '0 : timer + 1'b1;
      idx <= state != DATA ? '0 : sample ? idx + 3'd1 : idx;
      if (sample) sh[idx] <= rx_s;
      if (accept) dado <= sh;
      if (accept) botoes <= botoes_nx;
      byte_valido <= accept;
      erro_quadro <= frame_err ? 1'b1 : accept ? 1'b0 : erro_quadro;
      right_arrow_pressed <= accept && sh == 8'h52;
      left_arrow_pressed <= accept && sh == 8'h4C;
      enter_pressed <= accept && sh == 8'h45;
    end
endmodule

// File: tb/tb_arduino_rx_comandos.sv
// tb_arduino_rx_comandos: directed frame sequences checked against hand-computed command results
module tb_arduino_rx_comandos;
  localparam int DIV = 10;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic right_arrow_pressed, left_arrow_pressed, enter_pressed, byte_valido, erro_quadro;
  logic [12:0] botoes;
  logic [7:0] dado;
  int checks = 0, errors = 0;
  int cyc = 0, n_right = 0, n_left = 0, n_enter = 0, n_bv = 0, t_right = 0, t_enter = 0;
  int bv0;

  arduino_rx_comandos #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .right_arrow_pressed(right_arrow_pressed), .left_arrow_pressed(left_arrow_pressed),
    .enter_pressed(enter_pressed), .botoes(botoes), .dado(dado),
    .byte_valido(byte_valido), .erro_quadro(erro_quadro)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (right_arrow_pressed) begin n_right++; t_right = cyc; end
    if (left_arrow_pressed) n_left++;
    if (enter_pressed) begin n_enter++; t_enter = cyc; end
    if (byte_valido) n_bv++;
    if (right_arrow_pressed || left_arrow_pressed || enter_pressed) begin
      checks++;
      assert (int'(right_arrow_pressed) + int'(left_arrow_pressed) + int'(enter_pressed) == 1 && byte_valido)
      else begin
        errors++;
        $error("FAIL pulse_align: got r/l/e/bv %b%b%b%b expected one command with byte_valido",
               right_arrow_pressed, left_arrow_pressed, enter_pressed, byte_valido);
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_botoes", 16'(botoes), 16'h0000);
    check("reset_dado", 16'(dado), 16'h0000);
    check("reset_flags", {12'h0, byte_valido, erro_quadro, right_arrow_pressed, enter_pressed}, 16'h0000);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    send_frame(8'h52, 1'b1);
    repeat (3) @(negedge clock);
    check("r_count", 16'(n_right), 16'd1);
    check("r_bv_count", 16'(n_bv), 16'd1);
    check("r_dado", 16'(dado), 16'h0052);
    check("r_erro", 16'(erro_quadro), 16'h0000);

    send_frame(8'h85, 1'b1);
    check("set5", 16'(botoes), 16'h0020);
    send_frame(8'h8C, 1'b1);
    check("set12", 16'(botoes), 16'h1020);
    send_frame(8'hC5, 1'b1);
    check("clr5", 16'(botoes), 16'h1000);
    send_frame(8'h8D, 1'b1);
    check("key13_ignored", 16'(botoes), 16'h1000);
    check("key13_dado", 16'(dado), 16'h008D);
    check("key_no_cmds", 16'(n_right + n_left + n_enter), 16'd1);
    check("key_bv_count", 16'(n_bv), 16'd5);

    send_frame(8'h4C, 1'b0);
    repeat (30) @(negedge clock);
    check("brk_erro_held", 16'(erro_quadro), 16'h0001);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check("brk_erro", 16'(erro_quadro), 16'h0001);
    check("brk_no_left", 16'(n_left), 16'd0);
    check("brk_no_byte", 16'(n_bv), 16'd5);
    check("brk_dado_kept", 16'(dado), 16'h008D);
    send_frame(8'h45, 1'b1);
    repeat (2) @(negedge clock);
    check("brk_enter", 16'(n_enter), 16'd1);
    check("brk_erro_clr", 16'(erro_quadro), 16'h0000);

    bv0 = n_bv;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
    check("glitch_no_byte", 16'(n_bv), 16'(bv0));
    send_frame(8'h00, 1'b1);
    check("zero_clears", 16'(botoes), 16'h0000);
    check("zero_bv", 16'(n_bv), 16'(bv0 + 1));

    send_frame(8'h45, 1'b1);
    send_frame(8'h52, 1'b1);
    repeat (2) @(negedge clock);
    check("b2b_enter", 16'(n_enter), 16'd2);
    check("b2b_right", 16'(n_right), 16'd2);
    check("b2b_gap", 16'(t_right - t_enter), 16'(10 * DIV));

    send_frame(8'h80, 1'b1);
    send_frame(8'h81, 1'b1);
    check("pre_rst_botoes", 16'(botoes), 16'h0003);
    bv0 = n_bv;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    rx = 1'b1;
    #1;
    check("rst_botoes", 16'(botoes), 16'h0000);
    check("rst_dado", 16'(dado), 16'h0000);
    check("rst_flags", {12'h0, byte_valido, erro_quadro, left_arrow_pressed, enter_pressed}, 16'h0000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(8'h81, 1'b1);
    repeat (2) @(negedge clock);
    check("post_rst_botoes", 16'(botoes), 16'h0002);
    check("post_rst_one_byte", 16'(n_bv), 16'(bv0 + 1));
    check("post_rst_dado", 16'(dado), 16'h0081);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
